// File: rtl/radiant_trig_cfg_sequencer.sv
// Wishbone master that atomically reprograms one RADIANT trigger: save and clear the master
// enable, write the four per-trigger registers, then restore the saved master enable.
module radiant_trig_cfg_sequencer #(
  parameter int unsigned NUM_TRIG      = 4,
  parameter int unsigned NUM_CH        = 24,
  parameter int unsigned ONESHOT_WIDTH = 20,
  parameter int unsigned THRESH_WIDTH  = 5,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [3:0]               req_trig_i,
  input  logic                     req_en_i,
  input  logic [NUM_CH-1:0]        req_maskb_i,
  input  logic [ONESHOT_WIDTH-1:0] req_window_i,
  input  logic [THRESH_WIDTH-1:0]  req_thresh_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               err_code_o,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic                     wbm_we_o,
  output logic [8:0]               wbm_adr_o,
  output logic [31:0]              wbm_dat_o,
  output logic [3:0]               wbm_sel_o,
  input  logic [31:0]              wbm_dat_i,
  input  logic                     wbm_ack_i,
  input  logic                     wbm_err_i
);

  typedef enum logic [3:0] {
    StIdle, StRdMen, StWrMen0, StWrEn, StWrMask, StWrWin, StWrTh, StWrMenr, StGap, StDone, StErr
  } state_e;

  state_e                   state_q, state_d, nxt_q, nxt_d, follow;
  logic                     gap_q, gap_d;
  logic [7:0]               tmo_q, tmo_d;
  logic                     men_q, men_d;
  logic [3:0]               trig_q, trig_d;
  logic                     en_q, en_d;
  logic [NUM_CH-1:0]        maskb_q, maskb_d;
  logic [ONESHOT_WIDTH-1:0] window_q, window_d;
  logic [THRESH_WIDTH-1:0]  thresh_q, thresh_d;
  logic [1:0]               err_code_q, err_code_d;
  logic                     unused_dat;

  assign unused_dat = ^wbm_dat_i[31:1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      nxt_q      <= StIdle;
      gap_q      <= 1'b0;
      tmo_q      <= '0;
      men_q      <= 1'b0;
      trig_q     <= '0;
      en_q       <= 1'b0;
      maskb_q    <= '0;
      window_q   <= '0;
      thresh_q   <= '0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      nxt_q      <= nxt_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      men_q      <= men_d;
      trig_q     <= trig_d;
      en_q       <= en_d;
      maskb_q    <= maskb_d;
      window_q   <= window_d;
      thresh_q   <= thresh_d;
      err_code_q <= err_code_d;
    end
  end

  // Transaction that follows the current one once its gap has elapsed.
  always_comb begin
    follow = StIdle;
    case (state_q)
      StRdMen:  follow = StWrMen0;
      StWrMen0: follow = StWrEn;
      StWrEn:   follow = StWrMask;
      StWrMask: follow = StWrWin;
      StWrWin:  follow = StWrTh;
      StWrTh:   follow = StWrMenr;
      StWrMenr: follow = StDone;
      default:  follow = StIdle;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    nxt_d      = nxt_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    men_d      = men_q;
    trig_d     = trig_q;
    en_d       = en_q;
    maskb_d    = maskb_q;
    window_d   = window_q;
    thresh_d   = thresh_q;
    err_code_d = err_code_q;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          trig_d   = req_trig_i;
          en_d     = req_en_i;
          maskb_d  = req_maskb_i;
          window_d = req_window_i;
          thresh_d = req_thresh_i;
          tmo_d    = '0;
          if ({28'd0, req_trig_i} >= NUM_TRIG) begin
            err_code_d = 2'd1;
            state_d    = StErr;
          end else begin
            err_code_d = 2'd0;
            state_d    = StRdMen;
          end
        end
      end
      StGap: begin
        // Bus responses are ignored here so a trailing registered ack cannot leak forward.
        if (gap_q) begin
          state_d = nxt_q;
          tmo_d   = '0;
        end else begin
          gap_d = 1'b1;
        end
      end
      StDone, StErr: state_d = StIdle;
      default: begin
        if (wbm_err_i) begin
          err_code_d = 2'd2;
          state_d    = StErr;
        end else if (wbm_ack_i) begin
          if (state_q == StRdMen) men_d = wbm_dat_i[0];
          nxt_d   = follow;
          gap_d   = 1'b0;
          state_d = StGap;
        end else if (tmo_q == 8'(ACK_TIMEOUT - 1)) begin
          err_code_d = 2'd3;
          state_d    = StErr;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    busy_o     = !(state_q inside {StIdle, StDone, StErr});
    done_o     = (state_q == StDone);
    err_o      = (state_q == StErr);
    err_code_o = err_code_q;
    wbm_sel_o  = 4'hF;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_adr_o  = '0;
    wbm_dat_o  = '0;
    case (state_q)
      StRdMen: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
      end
      StWrMen0: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
      end
      StWrEn, StWrMask, StWrWin, StWrTh: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        // Per-trigger block at 0x100 + 16*T, register offset in bits [3:2].
        wbm_adr_o = {1'b1, trig_q, 4'h0};
        case (state_q)
          StWrEn: wbm_dat_o = {en_q, 31'b0};
          StWrMask: begin
            wbm_adr_o[3:2] = 2'd1;
            wbm_dat_o      = 32'(maskb_q);
          end
          StWrWin: begin
            wbm_adr_o[3:2] = 2'd2;
            wbm_dat_o      = 32'(window_q);
          end
          default: begin
            wbm_adr_o[3:2] = 2'd3;
            wbm_dat_o      = 32'(thresh_q);
          end
        endcase
      end
      StWrMenr: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_dat_o = {31'b0, men_q};
      end
      default: ;
    endcase
  end

endmodule
